shift_add_mult_32: RTL and testbench

- Multi-cycle unsigned 32x32 -> 64-bit shift-and-add multiplier.
- Sits directly upstream of the 64-bit ripple adder stage and drives that adder's a, b and cin inputs every cycle.
- Consumes the adder's 64-bit sum back into its accumulator.
- Provides a cheap multiply for the datapath without a combinational array multiplier.

---
 rtl/shift_add_mult_32_if.sv | 22 ++
 rtl/shift_add_mult_32.sv | 72 +++++++
 tb/tb_shift_add_mult_32.sv | 113 +++++++++++
 3 files changed

// File: rtl/shift_add_mult_32_if.sv
// shift_add_mult_32_if: request/result and adder-drive signals of the shift-and-add multiplier
interface shift_add_mult_32_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] product;
  logic        busy;
  logic        done;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic        add_cin;
  logic [63:0] add_s;
  logic        add_carry;
  modport slave (
    input  start, a, b, add_s, add_carry,
    output product, busy, done, add_a, add_b, add_cin
  );
  modport master (
    output start, a, b, add_s, add_carry,
    input  product, busy, done, add_a, add_b, add_cin
  );
endinterface

// File: rtl/shift_add_mult_32.sv
// shift_add_mult_32: 32x32->64 unsigned shift-and-add multiplier, one partial product per cycle
// through an external 64-bit adder.
module shift_add_mult_32 #(
  parameter int OPW = 32
) (
  input logic clk,
  input logic rst_n,
  shift_add_mult_32_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [2*OPW-1:0] acc;
  logic [2*OPW-1:0] mcand;
  logic [OPW-1:0] mplier;
  logic [5:0] count;
  logic [2*OPW-1:0] product;
  logic busy;
  logic done;
  logic unused_carry;
  assign bus.add_a = acc;
  assign bus.add_b = mplier[0] ? mcand : '0;
  assign bus.add_cin = 1'b0;
  assign bus.product = product;
  assign bus.busy = busy;
  assign bus.done = done;
  // the product never exceeds 64 bits, so the adder carry-out carries no information
  assign unused_carry = bus.add_carry;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      count <= '0;
      product <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mcand <= {{OPW{1'b0}}, bus.a};
          mplier <= bus.b;
          acc <= '0;
          count <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          acc <= bus.add_s;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          count <= count + 6'd1;
          if (count == 6'(OPW - 1)) begin
            product <= bus.add_s;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mult_32.sv
// tb_shift_add_mult_32: directed scoreboard bench; the bench itself plays the 64-bit ripple adder.
module tb_shift_add_mult_32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  shift_add_mult_32_if bus();
  shift_add_mult_32 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign {bus.add_carry, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 65'(bus.add_cin);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic mult(input logic [31:0] x, input logic [31:0] y, input int pulse_a, input int pulse_b, input int rst_at);
    logic [63:0] acc;
    logic [63:0] pp;
    logic [63:0] exp_p;
    int busy_n;
    bit seen;
    acc = '0;
    busy_n = 0;
    seen = 1'b0;
    exp_p = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    sb.push_back({32'h0, x} * {32'h0, y});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = ~x;
    bus.b = ~y;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_n++;
      check("add_cin", 64'(bus.add_cin), 64'd0);
      if (k < 32) begin
        pp = y[k] ? ({32'h0, x} << k) : 64'd0;
        check("add_a", bus.add_a, acc);
        check("add_b", bus.add_b, pp);
        acc = acc + pp;
      end
      if (k == rst_at) begin
        // reset together with a start request: reset must win
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.a = 32'd5;
        bus.b = 32'd5;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_product", bus.product, 64'd0);
        rst_n = 1'b1;
        bus.start = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("rst_no_capture", 64'(bus.busy), 64'd0);
        return;
      end
      if (bus.done) begin
        seen = 1'b1;
        exp_p = sb.pop_front();
        check("done_cycle", 64'(k), 64'd32);
        check("product", bus.product, exp_p);
      end
      if (k == pulse_a || k == pulse_b) begin
        bus.start = 1'b1;
        bus.a = 32'd1;
        bus.b = 32'd1;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    if (!seen) void'(sb.pop_front());
    check("busy_cycles", 64'(busy_n), 64'd33);
    @(negedge clk);
    bus.start = 1'b0;
    check("done_width", 64'(bus.done), 64'd0);
    check("busy_idle", 64'(bus.busy), 64'd0);
    if (seen) check("product_hold", bus.product, exp_p);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", bus.product, 64'd0);
    check("reset_add_a", bus.add_a, 64'd0);
    check("reset_add_b", bus.add_b, 64'd0);
    check("reset_add_cin", 64'(bus.add_cin), 64'd0);
    rst_n = 1'b1;
    mult(32'd3, 32'd5, -1, -1, -1);
    mult(32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1);
    mult(32'd0, 32'h12345678, -1, -1, -1);
    mult(32'h80000000, 32'd2, -1, -1, -1);
    mult(32'd7, 32'd9, 10, 32, -1);
    mult(32'd1, 32'd1, -1, -1, -1);
    mult(32'd100, 32'd200, -1, -1, 15);
    mult(32'd100, 32'd200, -1, -1, -1);
    mult($urandom, $urandom, -1, -1, -1);
    mult($urandom, $urandom, -1, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
